// File: rtl/key_debounce_pkg.sv
// Shared level constants and sizing helper for the push-button debounce slice.
package key_debounce_pkg;

  localparam logic KEY_RELEASED = 1'b1;
  localparam logic KEY_PRESSED  = 1'b0;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Counter width for a window of n cycles; it only has to hold n-1, and is never narrower than 1 bit.
  function automatic int debounce_cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: synchroniser, debounce window counter, stable level and edge strobes.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic key_n_in,
  output logic key_n_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain; reset to the released level.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync_q <= {SYNC_STAGES{KEY_RELEASED}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_in};
    end
  end

  // Accept a new level only after it has differed from the stable one for a full window;
  // any return to the stable level restarts the window from zero.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cnt_q         <= '0;
      key_n_out     <= KEY_RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync == key_n_out) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q         <= '0;
        key_n_out     <= sync;
        press_pulse   <= (sync == KEY_PRESSED);
        release_pulse <= (sync == KEY_RELEASED);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Push-button conditioning: per-key debounce cells plus sticky press capture and masked irq.
module key_debounce_ctrl
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_n_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] capture,
  input  logic [NUM_KEYS-1:0] capture_clr,
  input  logic [NUM_KEYS-1:0] irq_mask,
  output logic                irq
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_cell (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .key_n_in      (key_n_in[i]),
      .key_n_out     (key_n_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

  // Sticky press flags: write-1-to-clear, but a coincident press keeps the flag set.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      capture <= '0;
    end else begin
      capture <= (capture & ~capture_clr) | press_pulse;
    end
  end

  // Interrupt follows the enabled capture flags one cycle later.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(capture & irq_mask);
    end
  end

endmodule
